rca_config_unit: RTL and testbench
==================================

// Module: rca_config_unit
// PURPOSE
//  Execution-side responder for RCA configuration instructions issued as rca_inputs_t.
//  Decodes the config-kind flags and writes per-RCA storage: CPU src/dest register addresses,
//  grid mux selects, IO mux selects, result mux selects and IO-use masks.
//  Completes each instruction with its id toward writeback.
//  Serves the stored configuration of one selected RCA to the issue stage and the RCA grid.
// PARAMETERS
//  NUM_RCAS            rca_config::NUM_RCAS            number of RCAs with independent config
//  NUM_READ_PORTS      rca_config::NUM_READ_PORTS      CPU source ports per RCA
//  NUM_WRITE_PORTS     rca_config::NUM_WRITE_PORTS     CPU dest/result ports per RCA
//  NUM_GRID_MUXES      rca_config::NUM_GRID_MUXES      grid muxes per RCA
//  GRID_MUX_INPUTS     rca_config::GRID_MUX_INPUTS     inputs per grid mux (sel width = clog2)
//  GRID_NUM_ROWS       rca_config::GRID_NUM_ROWS       IO units per RCA, also io_use width
//  IO_UNIT_MUX_INPUTS  rca_config::IO_UNIT_MUX_INPUTS  inputs per IO-unit mux
// PORTS
//  clk                 in   1         clock
//  rst                 in   1         async active-high reset
//  issue_new_request   in   1         config instruction presented
//  issue_ready         out  1         unit can accept; transfer = new_request & ready
//  issue_id            in   id_t      instruction id
//  rca_inputs          in   rca_inputs_t  decoded config payload
//  cfg_rd_sel          in   clog2(NUM_RCAS)  RCA whose config drives the read outputs
//  rca_config          out  rca_config_t  src/dest reg addrs of cfg_rd_sel
//  grid_mux_sels       out  NUM_GRID_MUXES*clog2(GRID_MUX_INPUTS)  grid selects of cfg_rd_sel
//  io_mux_sels         out  GRID_NUM_ROWS*clog2(IO_UNIT_MUX_INPUTS)  IO selects of cfg_rd_sel
//  result_mux_sels     out  NUM_WRITE_PORTS*clog2(GRID_NUM_ROWS)  result selects of cfg_rd_sel
//  io_inp_use          out  GRID_NUM_ROWS  IO-use mask of cfg_rd_sel
//  config_pending      out  NUM_RCAS  bit r = config write to RCA r accepted, not yet acked
//  done_valid          out  1         completion available
//  done_id             out  id_t      id of completing instruction
//  done_ack            in   1         writeback consumed completion
// BEHAVIOUR
//  - FSM IDLE -> WRITE -> RESP -> IDLE.
//    issue_ready = (state==IDLE), combinational, no dependence on new_request.
//  - IDLE: on transfer, register rca_inputs, issue_id and rca_sel; set config_pending[rca_sel];
//    go to WRITE.
//  - WRITE (1 cycle): update the table of the latched rca_sel; go to RESP.
//  - RESP: done_valid=1 with done_id held stable until done_ack. On done_ack, clear
//    config_pending[sel] and go to IDLE. No new accept in the ack cycle (ready low).
//  - Latency: accept at edge N, table written at N+1, done_valid high after N+1,
//    read outputs reflect the new value in the same cycle done_valid rises.
//  - Kind priority when several flags are set: cpu_reg > grid_mux > io_mux > result_mux > io_use.
//    Only the highest-priority kind is written.
//  - No flags set, or rca_use_instr only: no table write, still completes with id.
//  - cpu_reg kind: cpu_src_dest_port=0 writes src[sel][cpu_port_sel]=cpu_reg_addr;
//    =1 writes dest[sel][cpu_port_sel]. A dest write with cpu_port_sel>=NUM_WRITE_PORTS is dropped.
//  - grid/io/result kinds: entry at grid_mux_addr / io_mux_addr / rca_result_mux_addr takes the
//    new_* select. Out-of-range addresses (>= count) are dropped.
//  - io_use kind: replace the whole mask with new_rca_io_inp_use.
//  - rca_sel >= NUM_RCAS: no write, still completes.
//  - cfg_rd_sel >= NUM_RCAS: read outputs are all zero.
//  - Packing: port k address occupies bits [5k+4:5k] of each flattened rca_config field.
//    Select vectors pack entry 0 at LSB.
//  - Read outputs are purely combinational from the tables; no write-to-read bypass.
//  - Reset (any time, incl. mid-op): state IDLE, all tables 0, done_valid 0, done_id 0,
//    config_pending 0. An in-flight instruction is dropped with no completion.
// STRUCTURE
//  - Add to the shared package: enum rca_cfg_kind_t {CFG_NONE, CFG_CPU_REG, CFG_GRID, CFG_IO,
//    CFG_RESULT, CFG_IO_USE}, plus a packed rca_cfg_req_t {kind, rca_sel, id, payload}.
//  - Sub-module rca_config_bank: storage for one RCA, holding a write port (kind, addr, data) and
//    all-read outputs. Instantiated NUM_RCAS times via generate.
//  - Top: FSM, kind priority encoder, bank write-enable demux, read mux on cfg_rd_sel.
// TESTING
//  1. Reset, then cpu_reg src write rca_sel=0 port=1 addr=5'd7 id=3.
//     -> ready low 2 cycles; done_valid, done_id=3; rca_config src field bits[9:5]=7.
//  2. Hold done_ack=0 for 5 cycles while new_request=1.
//     -> done_valid/done_id stable, issue_ready=0, config_pending[0]=1;
//     after ack -> pending 0, accept next cycle.
//  3. grid+io flags both set, grid_mux_addr=2 sel=3.
//     -> only grid entry 2=3 written; io table unchanged.
//  4. dest write port=NUM_WRITE_PORTS, and grid_mux_addr=NUM_GRID_MUXES.
//     -> tables unchanged; both still complete with their ids.
//  5. Write RCA1 io_use=4'b1010 with cfg_rd_sel=0.
//     -> io_inp_use stays 0; set cfg_rd_sel=1 -> 4'b1010.
//  6. Assert rst in WRITE state.
//     -> no done_valid ever for that id; tables 0; issue_ready=1 after rst deasserts.

Source files
------------

// File: rtl/rca_config_unit_pkg.sv
// -----------------------------------------------------------------------------
// rca_config_unit_pkg
// Shared types and sizing for the RCA configuration unit: the decoded
// instruction payload (rca_inputs_t), the CPU register-address view
// (rca_config_t), the internal request format (rca_cfg_req_t) and the
// priority decode that turns an instruction into a single table write.
// -----------------------------------------------------------------------------
package rca_config_unit_pkg;

    localparam int NUM_RCAS           = 3;
    localparam int NUM_READ_PORTS     = 3;
    localparam int NUM_WRITE_PORTS    = 2;
    localparam int NUM_GRID_MUXES     = 4;
    localparam int GRID_MUX_INPUTS    = 8;
    localparam int GRID_NUM_ROWS      = 4;
    localparam int IO_UNIT_MUX_INPUTS = 4;

    localparam int REG_ADDR_W   = 5;
    localparam int ID_W         = 4;
    localparam int RCA_SEL_W    = $clog2(NUM_RCAS);
    localparam int GRID_SEL_W   = $clog2(GRID_MUX_INPUTS);
    localparam int IO_SEL_W     = $clog2(IO_UNIT_MUX_INPUTS);
    localparam int RESULT_SEL_W = $clog2(GRID_NUM_ROWS);

    // Address fields are one value wider than the table size so that
    // out-of-range addresses can be expressed and must be dropped.
    localparam int PORT_SEL_W    = $clog2(NUM_READ_PORTS + 1);
    localparam int GRID_ADDR_W   = $clog2(NUM_GRID_MUXES + 1);
    localparam int IO_ADDR_W     = $clog2(GRID_NUM_ROWS + 1);
    localparam int RESULT_ADDR_W = $clog2(NUM_WRITE_PORTS + 1);

    localparam int GRID_SELS_W   = NUM_GRID_MUXES * GRID_SEL_W;
    localparam int IO_SELS_W     = GRID_NUM_ROWS * IO_SEL_W;
    localparam int RESULT_SELS_W = NUM_WRITE_PORTS * RESULT_SEL_W;

    localparam int CFG_ADDR_W = 4;
    localparam int CFG_DATA_W = 8;

    typedef logic [ID_W-1:0] id_t;

    typedef struct packed {
        logic [RCA_SEL_W-1:0]     rca_sel;
        logic                     rca_use_instr;
        logic                     rca_cpu_reg_config;
        logic                     rca_grid_mux_config;
        logic                     rca_io_mux_config;
        logic                     rca_result_mux_config;
        logic                     rca_io_inp_use_config;
        logic                     cpu_src_dest_port;
        logic [PORT_SEL_W-1:0]    cpu_port_sel;
        logic [REG_ADDR_W-1:0]    cpu_reg_addr;
        logic [GRID_ADDR_W-1:0]   grid_mux_addr;
        logic [GRID_SEL_W-1:0]    new_grid_mux_sel;
        logic [IO_ADDR_W-1:0]     io_mux_addr;
        logic [IO_SEL_W-1:0]      new_io_mux_sel;
        logic [RESULT_ADDR_W-1:0] rca_result_mux_addr;
        logic [RESULT_SEL_W-1:0]  new_rca_result_mux_sel;
        logic [GRID_NUM_ROWS-1:0] new_rca_io_inp_use;
    } rca_inputs_t;

    typedef struct packed {
        logic [NUM_READ_PORTS*REG_ADDR_W-1:0]  rca_cpu_src_reg_addrs;
        logic [NUM_WRITE_PORTS*REG_ADDR_W-1:0] rca_cpu_dest_reg_addrs;
    } rca_config_t;

    typedef enum logic [2:0] {
        CFG_NONE,
        CFG_CPU_REG,
        CFG_GRID,
        CFG_IO,
        CFG_RESULT,
        CFG_IO_USE
    } rca_cfg_kind_t;

    typedef struct packed {
        logic                  dest;
        logic [CFG_ADDR_W-1:0] addr;
        logic [CFG_DATA_W-1:0] data;
    } rca_cfg_payload_t;

    typedef struct packed {
        rca_cfg_kind_t    kind;
        logic [RCA_SEL_W-1:0] rca_sel;
        id_t              id;
        rca_cfg_payload_t payload;
    } rca_cfg_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RESP
    } rca_cfg_state_t;

    // Collapse the flag set to the single highest-priority kind; the other
    // kinds in the same instruction are ignored.
    function automatic rca_cfg_req_t decode_cfg_req(input rca_inputs_t in, input id_t id);
        rca_cfg_req_t r;
        r         = '0;
        r.kind    = CFG_NONE;
        r.rca_sel = in.rca_sel;
        r.id      = id;
        if (in.rca_cpu_reg_config) begin
            r.kind         = CFG_CPU_REG;
            r.payload.dest = in.cpu_src_dest_port;
            r.payload.addr = CFG_ADDR_W'(in.cpu_port_sel);
            r.payload.data = CFG_DATA_W'(in.cpu_reg_addr);
        end else if (in.rca_grid_mux_config) begin
            r.kind         = CFG_GRID;
            r.payload.addr = CFG_ADDR_W'(in.grid_mux_addr);
            r.payload.data = CFG_DATA_W'(in.new_grid_mux_sel);
        end else if (in.rca_io_mux_config) begin
            r.kind         = CFG_IO;
            r.payload.addr = CFG_ADDR_W'(in.io_mux_addr);
            r.payload.data = CFG_DATA_W'(in.new_io_mux_sel);
        end else if (in.rca_result_mux_config) begin
            r.kind         = CFG_RESULT;
            r.payload.addr = CFG_ADDR_W'(in.rca_result_mux_addr);
            r.payload.data = CFG_DATA_W'(in.new_rca_result_mux_sel);
        end else if (in.rca_io_inp_use_config) begin
            r.kind         = CFG_IO_USE;
            r.payload.data = CFG_DATA_W'(in.new_rca_io_inp_use);
        end
        return r;
    endfunction

endpackage

// File: rtl/rca_config_unit_if.sv
// -----------------------------------------------------------------------------
// rca_config_unit_if
// Issue/completion handshake between the issue stage (master) and the RCA
// configuration unit (slave).
//   issue_new_request/issue_ready/issue_id/rca_inputs : instruction transfer
//   done_valid/done_id/done_ack                       : completion to writeback
// -----------------------------------------------------------------------------
interface rca_config_unit_if;
    import rca_config_unit_pkg::*;

    logic        issue_new_request;
    logic        issue_ready;
    id_t         issue_id;
    rca_inputs_t rca_inputs;
    logic        done_valid;
    id_t         done_id;
    logic        done_ack;

    modport master (
        output issue_new_request, issue_id, rca_inputs, done_ack,
        input  issue_ready, done_valid, done_id
    );

    modport slave (
        input  issue_new_request, issue_id, rca_inputs, done_ack,
        output issue_ready, done_valid, done_id
    );

endinterface

// File: rtl/rca_config_unit_bank.sv
// -----------------------------------------------------------------------------
// rca_config_bank
// Configuration storage for one RCA.
//   clk, rst          : clock, async active-high reset (clears all entries)
//   wr_en             : perform the write described by wr_kind/wr_addr/wr_data
//   wr_dest           : for CPU register writes, 1 = dest table, 0 = src table
//   cfg               : packed src/dest CPU register addresses
//   grid_sels/io_sels/result_sels : select tables, entry 0 at LSB
//   io_use            : IO-use mask
// -----------------------------------------------------------------------------
module rca_config_bank
    import rca_config_unit_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  rca_cfg_kind_t            wr_kind,
    input  logic                     wr_dest,
    input  logic [CFG_ADDR_W-1:0]    wr_addr,
    input  logic [CFG_DATA_W-1:0]    wr_data,
    output rca_config_t              cfg,
    output logic [GRID_SELS_W-1:0]   grid_sels,
    output logic [IO_SELS_W-1:0]     io_sels,
    output logic [RESULT_SELS_W-1:0] result_sels,
    output logic [GRID_NUM_ROWS-1:0] io_use
);

    localparam int SRC_IDX_W    = $clog2(NUM_READ_PORTS);
    localparam int DEST_IDX_W   = $clog2(NUM_WRITE_PORTS);
    localparam int GRID_IDX_W   = $clog2(NUM_GRID_MUXES);
    localparam int IO_IDX_W     = $clog2(GRID_NUM_ROWS);
    localparam int RESULT_IDX_W = $clog2(NUM_WRITE_PORTS);

    logic [NUM_READ_PORTS-1:0][REG_ADDR_W-1:0]    src_q;
    logic [NUM_WRITE_PORTS-1:0][REG_ADDR_W-1:0]   dest_q;
    logic [NUM_GRID_MUXES-1:0][GRID_SEL_W-1:0]    grid_q;
    logic [GRID_NUM_ROWS-1:0][IO_SEL_W-1:0]       io_q;
    logic [NUM_WRITE_PORTS-1:0][RESULT_SEL_W-1:0] result_q;
    logic [GRID_NUM_ROWS-1:0]                     use_q;

    // Upper payload bits carry nothing for any kind of this configuration.
    logic unused_data_bits;
    assign unused_data_bits = ^wr_data[CFG_DATA_W-1:REG_ADDR_W];

    // Single write port: the kind picks the table, the full (unwrapped)
    // address is range-checked so an out-of-range write never aliases onto
    // a valid entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q    <= '0;
            dest_q   <= '0;
            grid_q   <= '0;
            io_q     <= '0;
            result_q <= '0;
            use_q    <= '0;
        end else if (wr_en) begin
            case (wr_kind)
                CFG_CPU_REG: begin
                    if (wr_dest) begin
                        if (int'(wr_addr) < NUM_WRITE_PORTS)
                            dest_q[wr_addr[DEST_IDX_W-1:0]] <= wr_data[REG_ADDR_W-1:0];
                    end else if (int'(wr_addr) < NUM_READ_PORTS) begin
                        src_q[wr_addr[SRC_IDX_W-1:0]] <= wr_data[REG_ADDR_W-1:0];
                    end
                end
                CFG_GRID: begin
                    if (int'(wr_addr) < NUM_GRID_MUXES)
                        grid_q[wr_addr[GRID_IDX_W-1:0]] <= wr_data[GRID_SEL_W-1:0];
                end
                CFG_IO: begin
                    if (int'(wr_addr) < GRID_NUM_ROWS)
                        io_q[wr_addr[IO_IDX_W-1:0]] <= wr_data[IO_SEL_W-1:0];
                end
                CFG_RESULT: begin
                    if (int'(wr_addr) < NUM_WRITE_PORTS)
                        result_q[wr_addr[RESULT_IDX_W-1:0]] <= wr_data[RESULT_SEL_W-1:0];
                end
                CFG_IO_USE: use_q <= wr_data[GRID_NUM_ROWS-1:0];
                default: ;
            endcase
        end
    end

    assign cfg.rca_cpu_src_reg_addrs  = src_q;
    assign cfg.rca_cpu_dest_reg_addrs = dest_q;
    assign grid_sels                  = grid_q;
    assign io_sels                    = io_q;
    assign result_sels                = result_q;
    assign io_use                     = use_q;

endmodule

// File: rtl/rca_config_unit.sv
// -----------------------------------------------------------------------------
// rca_config_unit
// Accepts RCA configuration instructions, writes the per-RCA tables one cycle
// after accept, then holds a completion until writeback acknowledges it.
//   clk, rst        : clock, async active-high reset
//   bus (slave)     : issue handshake in, completion handshake out
//   cfg_rd_sel      : RCA whose stored configuration drives the read outputs
//   rca_config, grid_mux_sels, io_mux_sels, result_mux_sels, io_inp_use :
//                     combinational view of RCA cfg_rd_sel (zero if out of range)
//   config_pending  : per-RCA flag, set on accept, cleared on completion ack
// -----------------------------------------------------------------------------
module rca_config_unit
    import rca_config_unit_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    rca_config_unit_if.slave         bus,
    input  logic [RCA_SEL_W-1:0]     cfg_rd_sel,
    output rca_config_t              rca_config,
    output logic [GRID_SELS_W-1:0]   grid_mux_sels,
    output logic [IO_SELS_W-1:0]     io_mux_sels,
    output logic [RESULT_SELS_W-1:0] result_mux_sels,
    output logic [GRID_NUM_ROWS-1:0] io_inp_use,
    output logic [NUM_RCAS-1:0]      config_pending
);

    rca_cfg_state_t state_q, state_d;
    rca_cfg_req_t   req_in, req_q;
    logic           accept;
    logic [NUM_RCAS-1:0] pending_q;

    rca_config_t              bank_cfg    [NUM_RCAS];
    logic [GRID_SELS_W-1:0]   bank_grid   [NUM_RCAS];
    logic [IO_SELS_W-1:0]     bank_io     [NUM_RCAS];
    logic [RESULT_SELS_W-1:0] bank_result [NUM_RCAS];
    logic [GRID_NUM_ROWS-1:0] bank_use    [NUM_RCAS];

    assign req_in          = decode_cfg_req(bus.rca_inputs, bus.issue_id);
    assign bus.issue_ready = (state_q == ST_IDLE);
    assign accept          = bus.issue_new_request && bus.issue_ready;
    assign bus.done_valid  = (state_q == ST_RESP);
    assign bus.done_id     = req_q.id;
    assign config_pending  = pending_q;

    // State register; reset drops any instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // One cycle of table write after accept, then wait for the ack. Ready
    // is only high in IDLE, so the ack cycle itself never accepts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_WRITE;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  if (bus.done_ack) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Latch the already-prioritised request at accept so the write and the
    // completion id come from a stable copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         req_q <= '0;
        else if (accept) req_q <= req_in;
    end

    // Pending flags track accepted-but-unacknowledged writes per RCA; an
    // out-of-range RCA has no flag to set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            if (accept && (int'(req_in.rca_sel) < NUM_RCAS))
                pending_q[req_in.rca_sel] <= 1'b1;
            if ((state_q == ST_RESP) && bus.done_ack && (int'(req_q.rca_sel) < NUM_RCAS))
                pending_q[req_q.rca_sel] <= 1'b0;
        end
    end

    for (genvar r = 0; r < NUM_RCAS; r++) begin : g_bank
        rca_config_bank u_bank (
            .clk         (clk),
            .rst         (rst),
            .wr_en       ((state_q == ST_WRITE) && (int'(req_q.rca_sel) == r)),
            .wr_kind     (req_q.kind),
            .wr_dest     (req_q.payload.dest),
            .wr_addr     (req_q.payload.addr),
            .wr_data     (req_q.payload.data),
            .cfg         (bank_cfg[r]),
            .grid_sels   (bank_grid[r]),
            .io_sels     (bank_io[r]),
            .result_sels (bank_result[r]),
            .io_use      (bank_use[r])
        );
    end

    // Read mux straight off the tables; a select past the last RCA reads zero.
    always_comb begin
        rca_config      = '0;
        grid_mux_sels   = '0;
        io_mux_sels     = '0;
        result_mux_sels = '0;
        io_inp_use      = '0;
        if (int'(cfg_rd_sel) < NUM_RCAS) begin
            rca_config      = bank_cfg[cfg_rd_sel];
            grid_mux_sels   = bank_grid[cfg_rd_sel];
            io_mux_sels     = bank_io[cfg_rd_sel];
            result_mux_sels = bank_result[cfg_rd_sel];
            io_inp_use      = bank_use[cfg_rd_sel];
        end
    end

endmodule

// File: tb/tb_rca_config_unit.sv
// -----------------------------------------------------------------------------
// tb_rca_config_unit
// Drives directed and random configuration instructions into rca_config_unit.
// A table model predicts each completion (id plus the read-out view of the
// selected RCA); a monitor compares on every rising done_valid.
// -----------------------------------------------------------------------------
module tb_rca_config_unit;
    import rca_config_unit_pkg::*;

    logic clk;
    logic rst;
    logic [RCA_SEL_W-1:0]     cfg_rd_sel;
    rca_config_t              rca_config;
    logic [GRID_SELS_W-1:0]   grid_mux_sels;
    logic [IO_SELS_W-1:0]     io_mux_sels;
    logic [RESULT_SELS_W-1:0] result_mux_sels;
    logic [GRID_NUM_ROWS-1:0] io_inp_use;
    logic [NUM_RCAS-1:0]      config_pending;

    rca_config_unit_if bus();

    rca_config_unit dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .cfg_rd_sel      (cfg_rd_sel),
        .rca_config      (rca_config),
        .grid_mux_sels   (grid_mux_sels),
        .io_mux_sels     (io_mux_sels),
        .result_mux_sels (result_mux_sels),
        .io_inp_use      (io_inp_use),
        .config_pending  (config_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        id_t                      id;
        rca_config_t              cfg;
        logic [GRID_SELS_W-1:0]   grid;
        logic [IO_SELS_W-1:0]     io;
        logic [RESULT_SELS_W-1:0] res;
        logic [GRID_NUM_ROWS-1:0] use_mask;
    } exp_t;

    exp_t exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    int m_src [NUM_RCAS][NUM_READ_PORTS];
    int m_dest[NUM_RCAS][NUM_WRITE_PORTS];
    int m_grid[NUM_RCAS][NUM_GRID_MUXES];
    int m_io  [NUM_RCAS][GRID_NUM_ROWS];
    int m_res [NUM_RCAS][NUM_WRITE_PORTS];
    int m_use [NUM_RCAS];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void modelReset();
        for (int r = 0; r < NUM_RCAS; r++) begin
            for (int p = 0; p < NUM_READ_PORTS; p++)  m_src[r][p]  = 0;
            for (int p = 0; p < NUM_WRITE_PORTS; p++) m_dest[r][p] = 0;
            for (int p = 0; p < NUM_GRID_MUXES; p++)  m_grid[r][p] = 0;
            for (int p = 0; p < GRID_NUM_ROWS; p++)   m_io[r][p]   = 0;
            for (int p = 0; p < NUM_WRITE_PORTS; p++) m_res[r][p]  = 0;
            m_use[r] = 0;
        end
    endfunction

    function automatic void modelApply(input rca_inputs_t in);
        int s;
        s = int'(in.rca_sel);
        if (s >= NUM_RCAS) return;
        if (in.rca_cpu_reg_config) begin
            if (in.cpu_src_dest_port) begin
                if (int'(in.cpu_port_sel) < NUM_WRITE_PORTS) m_dest[s][in.cpu_port_sel] = int'(in.cpu_reg_addr);
            end else if (int'(in.cpu_port_sel) < NUM_READ_PORTS) begin
                m_src[s][in.cpu_port_sel] = int'(in.cpu_reg_addr);
            end
        end else if (in.rca_grid_mux_config) begin
            if (int'(in.grid_mux_addr) < NUM_GRID_MUXES) m_grid[s][in.grid_mux_addr] = int'(in.new_grid_mux_sel);
        end else if (in.rca_io_mux_config) begin
            if (int'(in.io_mux_addr) < GRID_NUM_ROWS) m_io[s][in.io_mux_addr] = int'(in.new_io_mux_sel);
        end else if (in.rca_result_mux_config) begin
            if (int'(in.rca_result_mux_addr) < NUM_WRITE_PORTS)
                m_res[s][in.rca_result_mux_addr] = int'(in.new_rca_result_mux_sel);
        end else if (in.rca_io_inp_use_config) begin
            m_use[s] = int'(in.new_rca_io_inp_use);
        end
    endfunction

    function automatic exp_t modelView(input int rd, input id_t id);
        exp_t e;
        e.id = id;
        e.cfg = '0; e.grid = '0; e.io = '0; e.res = '0; e.use_mask = '0;
        if (rd < NUM_RCAS) begin
            for (int p = 0; p < NUM_READ_PORTS; p++)
                e.cfg.rca_cpu_src_reg_addrs[p*REG_ADDR_W +: REG_ADDR_W] = REG_ADDR_W'(m_src[rd][p]);
            for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                e.cfg.rca_cpu_dest_reg_addrs[p*REG_ADDR_W +: REG_ADDR_W] = REG_ADDR_W'(m_dest[rd][p]);
                e.res[p*RESULT_SEL_W +: RESULT_SEL_W] = RESULT_SEL_W'(m_res[rd][p]);
            end
            for (int p = 0; p < NUM_GRID_MUXES; p++)
                e.grid[p*GRID_SEL_W +: GRID_SEL_W] = GRID_SEL_W'(m_grid[rd][p]);
            for (int p = 0; p < GRID_NUM_ROWS; p++)
                e.io[p*IO_SEL_W +: IO_SEL_W] = IO_SEL_W'(m_io[rd][p]);
            e.use_mask = GRID_NUM_ROWS'(m_use[rd]);
        end
        return e;
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkPending(input string name, input int sel, input logic bit_val);
        if (sel < NUM_RCAS) checkOutput(name, 64'(config_pending[sel]), 64'(bit_val));
        else                checkOutput(name, 64'(config_pending), 64'(0));
    endtask

    // Issue one instruction, check the handshake timing, hold the completion
    // for 'hold' cycles, then acknowledge.
    task automatic applyStimulus(input rca_inputs_t in, input id_t id, input int hold, input bit keep_req);
        int n;
        int sel;
        sel = int'(in.rca_sel);
        n = 0;
        while (!bus.issue_ready && n < 20) begin stepCycle(); n++; end
        checkOutput("ready_before_issue", 64'(bus.issue_ready), 64'(1));
        modelApply(in);
        exp_q.push_back(modelView(int'(cfg_rd_sel), id));
        bus.rca_inputs        = in;
        bus.issue_id          = id;
        bus.issue_new_request = 1'b1;
        stepCycle();
        if (!keep_req) bus.issue_new_request = 1'b0;
        checkOutput("ready_low_write", 64'(bus.issue_ready), 64'(0));
        checkPending("pending_set", sel, 1'b1);
        n = 0;
        while (!bus.done_valid && n < 10) begin stepCycle(); n++; end
        checkOutput("done_latency", 64'(n), 64'(1));
        for (int h = 0; h < hold; h++) begin
            checkOutput("hold_done_valid", 64'(bus.done_valid), 64'(1));
            checkOutput("hold_done_id", 64'(bus.done_id), 64'(id));
            checkOutput("hold_ready_low", 64'(bus.issue_ready), 64'(0));
            checkPending("hold_pending", sel, 1'b1);
            stepCycle();
        end
        checkOutput("ready_low_resp", 64'(bus.issue_ready), 64'(0));
        checkOutput("done_id", 64'(bus.done_id), 64'(id));
        bus.done_ack = 1'b1;
        stepCycle();
        bus.done_ack          = 1'b0;
        bus.issue_new_request = 1'b0;
        checkOutput("ready_after_ack", 64'(bus.issue_ready), 64'(1));
        checkOutput("done_valid_after_ack", 64'(bus.done_valid), 64'(0));
        checkPending("pending_cleared", sel, 1'b0);
    endtask

    // Monitor: every rising done_valid must match the oldest prediction.
    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (bus.done_valid && !prev) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_done", 64'(bus.done_valid), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("mon_done_id", 64'(bus.done_id), 64'(e.id));
                        checkOutput("mon_rca_config", 64'(rca_config), 64'(e.cfg));
                        checkOutput("mon_grid_sels", 64'(grid_mux_sels), 64'(e.grid));
                        checkOutput("mon_io_sels", 64'(io_mux_sels), 64'(e.io));
                        checkOutput("mon_result_sels", 64'(result_mux_sels), 64'(e.res));
                        checkOutput("mon_io_use", 64'(io_inp_use), 64'(e.use_mask));
                    end
                end
                prev = bus.done_valid;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        rca_inputs_t in;
        exp_t        v;
        int          n;

        rst                   = 1'b1;
        cfg_rd_sel            = '0;
        bus.issue_new_request = 1'b0;
        bus.issue_id          = '0;
        bus.rca_inputs        = '0;
        bus.done_ack          = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("reset_ready", 64'(bus.issue_ready), 64'(1));
        checkOutput("reset_done_valid", 64'(bus.done_valid), 64'(0));
        checkOutput("reset_done_id", 64'(bus.done_id), 64'(0));
        checkOutput("reset_pending", 64'(config_pending), 64'(0));
        checkOutput("reset_rca_config", 64'(rca_config), 64'(0));
        checkOutput("reset_io_use", 64'(io_inp_use), 64'(0));

        $display("[TB] directed: cpu src write");
        in = '0;
        in.rca_sel = 0; in.rca_cpu_reg_config = 1'b1; in.cpu_src_dest_port = 1'b0;
        in.cpu_port_sel = 1; in.cpu_reg_addr = 5'd7;
        applyStimulus(in, 4'd3, 0, 1'b0);
        checkOutput("src_port1", 64'(rca_config.rca_cpu_src_reg_addrs[9:5]), 64'(7));

        $display("[TB] directed: long ack hold with request asserted");
        in = '0;
        in.rca_sel = 0; in.rca_result_mux_config = 1'b1;
        in.rca_result_mux_addr = 1; in.new_rca_result_mux_sel = 2;
        applyStimulus(in, 4'd5, 5, 1'b1);

        $display("[TB] directed: grid and io flags together");
        in = '0;
        in.rca_sel = 0; in.rca_grid_mux_config = 1'b1; in.rca_io_mux_config = 1'b1;
        in.grid_mux_addr = 2; in.new_grid_mux_sel = 3; in.io_mux_addr = 1; in.new_io_mux_sel = 2;
        applyStimulus(in, 4'd9, 1, 1'b0);
        checkOutput("grid_entry2", 64'(grid_mux_sels[8:6]), 64'(3));
        checkOutput("io_untouched", 64'(io_mux_sels), 64'(0));

        $display("[TB] directed: out-of-range addresses");
        in = '0;
        in.rca_sel = 0; in.rca_cpu_reg_config = 1'b1; in.cpu_src_dest_port = 1'b1;
        in.cpu_port_sel = PORT_SEL_W'(NUM_WRITE_PORTS); in.cpu_reg_addr = 5'd21;
        applyStimulus(in, 4'd6, 0, 1'b0);
        in = '0;
        in.rca_sel = 0; in.rca_grid_mux_config = 1'b1;
        in.grid_mux_addr = GRID_ADDR_W'(NUM_GRID_MUXES); in.new_grid_mux_sel = 5;
        applyStimulus(in, 4'd7, 0, 1'b0);
        v = modelView(0, 4'd0);
        checkOutput("dest_unchanged", 64'(rca_config.rca_cpu_dest_reg_addrs), 64'(v.cfg.rca_cpu_dest_reg_addrs));
        checkOutput("grid_unchanged", 64'(grid_mux_sels), 64'(v.grid));

        $display("[TB] directed: io_use on RCA1 viewed through both selects");
        in = '0;
        in.rca_sel = 1; in.rca_io_inp_use_config = 1'b1; in.new_rca_io_inp_use = 4'b1010;
        cfg_rd_sel = 0;
        applyStimulus(in, 4'd8, 0, 1'b0);
        checkOutput("io_use_rca0", 64'(io_inp_use), 64'(0));
        cfg_rd_sel = 1;
        #1;
        checkOutput("io_use_rca1", 64'(io_inp_use), 64'(4'b1010));

        $display("[TB] random instructions");
        for (int i = 0; i < 40; i++) begin
            in = '0;
            in.rca_sel                = RCA_SEL_W'($urandom_range(0, 3));
            in.rca_use_instr          = ($urandom_range(0, 3) == 0);
            in.rca_cpu_reg_config     = ($urandom_range(0, 3) == 0);
            in.rca_grid_mux_config    = ($urandom_range(0, 2) == 0);
            in.rca_io_mux_config      = ($urandom_range(0, 2) == 0);
            in.rca_result_mux_config  = ($urandom_range(0, 2) == 0);
            in.rca_io_inp_use_config  = ($urandom_range(0, 2) == 0);
            in.cpu_src_dest_port      = 1'($urandom);
            in.cpu_port_sel           = PORT_SEL_W'($urandom);
            in.cpu_reg_addr           = REG_ADDR_W'($urandom);
            in.grid_mux_addr          = GRID_ADDR_W'($urandom_range(0, NUM_GRID_MUXES));
            in.new_grid_mux_sel       = GRID_SEL_W'($urandom);
            in.io_mux_addr            = IO_ADDR_W'($urandom_range(0, GRID_NUM_ROWS));
            in.new_io_mux_sel         = IO_SEL_W'($urandom);
            in.rca_result_mux_addr    = RESULT_ADDR_W'($urandom);
            in.new_rca_result_mux_sel = RESULT_SEL_W'($urandom);
            in.new_rca_io_inp_use     = GRID_NUM_ROWS'($urandom);
            cfg_rd_sel = RCA_SEL_W'($urandom_range(0, 3));
            applyStimulus(in, ID_W'($urandom), $urandom_range(0, 2), 1'($urandom));
        end

        $display("[TB] directed: reset during table write");
        in = '0;
        in.rca_sel = 2; in.rca_io_inp_use_config = 1'b1; in.new_rca_io_inp_use = 4'b0110;
        bus.rca_inputs        = in;
        bus.issue_id          = 4'd12;
        bus.issue_new_request = 1'b1;
        stepCycle();
        bus.issue_new_request = 1'b0;
        checkOutput("in_write_state", 64'(bus.issue_ready), 64'(0));
        rst = 1'b1;
        stepCycle();
        stepCycle();
        rst = 1'b0;
        modelReset();
        checkOutput("post_rst_ready", 64'(bus.issue_ready), 64'(1));
        checkOutput("post_rst_done_valid", 64'(bus.done_valid), 64'(0));
        checkOutput("post_rst_done_id", 64'(bus.done_id), 64'(0));
        checkOutput("post_rst_pending", 64'(config_pending), 64'(0));
        for (int r = 0; r < NUM_RCAS; r++) begin
            cfg_rd_sel = RCA_SEL_W'(r);
            #1;
            v = modelView(r, 4'd0);
            checkOutput("post_rst_rca_config", 64'(rca_config), 64'(v.cfg));
            checkOutput("post_rst_grid", 64'(grid_mux_sels), 64'(v.grid));
            checkOutput("post_rst_io_use", 64'(io_inp_use), 64'(v.use_mask));
        end
        repeat (5) stepCycle();
        checkOutput("no_done_after_rst", 64'(bus.done_valid), 64'(0));

        cfg_rd_sel = 2;
        in = '0;
        in.rca_sel = 2; in.rca_cpu_reg_config = 1'b1; in.cpu_src_dest_port = 1'b1;
        in.cpu_port_sel = 1; in.cpu_reg_addr = 5'd30;
        applyStimulus(in, 4'd14, 0, 1'b0);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin stepCycle(); n++; end
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
